// File: rtl/pharmacy_pkg.sv
// Shared encodings for the pharmacy check-in scheduler: memory command modes,
// default sizing, FSM state encoding and kiosk field extraction helpers.
package pharmacy_pkg;

    localparam int CAPACITY_DEF     = 10;
    localparam int LIST_TIMEOUT_DEF = 16;

    localparam logic [1:0] MODE_LIST    = 2'b00;
    localparam logic [1:0] MODE_NOP     = 2'b01;
    localparam logic [1:0] MODE_CHECKIN = 2'b10;
    localparam logic [1:0] MODE_DELETE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CMD        = 3'd1,
        ST_ACK        = 3'd2,
        ST_LIST_START = 3'd3,
        ST_LIST_RUN   = 3'd4,
        ST_LIST_END   = 3'd5
    } state_t;

    // Who owns the transaction currently in flight.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_SRV   = 2'd1,
        OWN_LST   = 2'd2,
        OWN_KIOSK = 2'd3
    } owner_t;

    // Student ID of kiosk idx from the packed kiosk ID bus.
    function automatic logic [4:0] kiosk_id(input logic [9:0] ids, input logic idx);
        return idx ? ids[9:5] : ids[4:0];
    endfunction

    // Check-in time of kiosk idx from the packed kiosk time bus.
    function automatic logic [7:0] kiosk_time(input logic [15:0] times, input logic idx);
        return idx ? times[15:8] : times[7:0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. ptr names the kiosk that is preferred next;
// after a grant the pointer moves past the granted kiosk.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr;

    // Pick the preferred kiosk if it requests, otherwise the other one.
    always_comb begin
        gnt_idx = ptr;
        if (!req[ptr]) gnt_idx = ~ptr;
        gnt = 2'b00;
        if (req[gnt_idx]) gnt[gnt_idx] = 1'b1;
    end

    // Move the pointer past whichever kiosk was just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance && (|req)) begin
            ptr <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/pharmacy_sched.sv
// Pharmacy check-in scheduler: arbitrates kiosk check-ins, pharmacist serves
// and list requests onto a single queue memory command port.
//
// Handshake: every requester (k_req[i], srv_req, lst_req) raises its request
// and holds it until it sees its one-cycle response (k_ack/k_nack, srv_ack/
// srv_nack, lst_done); it drops the request the cycle after that response.
// Requests are only sampled in IDLE, so a held request is never lost.
import pharmacy_pkg::*;

module pharmacy_sched #(
    parameter int CAPACITY     = CAPACITY_DEF,
    parameter int LIST_TIMEOUT = LIST_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  k_req,
    input  logic [9:0]  k_id,
    input  logic [15:0] k_time,
    output logic [1:0]  k_ack,
    output logic [1:0]  k_nack,
    input  logic        srv_req,
    output logic        srv_ack,
    output logic        srv_nack,
    input  logic        lst_req,
    output logic        lst_valid,
    output logic [4:0]  lst_id,
    output logic        lst_done,
    output logic [1:0]  mem_mode,
    output logic [4:0]  mem_id,
    output logic [7:0]  mem_time,
    input  logic [4:0]  mem_list,
    input  logic        mem_busy,
    input  logic        mem_ready,
    output logic [3:0]  occupancy
);

    state_t     state;
    owner_t     owner;
    logic       kiosk_sel;
    logic [3:0] lst_cnt;
    logic [7:0] run_cnt;

    logic [1:0] gnt;
    logic       gnt_idx;
    logic       arb_advance;
    logic [4:0] sel_id;
    logic [7:0] sel_time;

    // Kiosks only get a grant in IDLE when neither serve nor list is asking.
    assign arb_advance = (state == ST_IDLE) && !srv_req && !lst_req;
    assign sel_id      = kiosk_id(k_id, gnt_idx);
    assign sel_time    = kiosk_time(k_time, gnt_idx);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (k_req),
        .advance (arb_advance),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Main scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            kiosk_sel <= 1'b0;
            lst_cnt   <= 4'd0;
            run_cnt   <= 8'd0;
            mem_mode  <= MODE_NOP;
            mem_id    <= 5'd0;
            mem_time  <= 8'd0;
            lst_id    <= 5'd0;
            lst_valid <= 1'b0;
            lst_done  <= 1'b0;
            k_ack     <= 2'b00;
            k_nack    <= 2'b00;
            srv_ack   <= 1'b0;
            srv_nack  <= 1'b0;
            occupancy <= 4'd0;
        end else begin
            // Response strobes are single-cycle unless set below.
            k_ack     <= 2'b00;
            k_nack    <= 2'b00;
            srv_ack   <= 1'b0;
            srv_nack  <= 1'b0;
            lst_valid <= 1'b0;
            lst_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    mem_mode <= MODE_NOP;
                    if (srv_req) begin
                        owner <= OWN_SRV;
                        if (occupancy == 4'd0) begin
                            srv_nack <= 1'b1;
                            state    <= ST_ACK;
                        end else begin
                            mem_mode <= MODE_DELETE;
                            state    <= ST_CMD;
                        end
                    end else if (lst_req) begin
                        owner <= OWN_LST;
                        if (occupancy == 4'd0) begin
                            lst_done <= 1'b1;
                            state    <= ST_ACK;
                        end else begin
                            mem_mode <= MODE_LIST;
                            state    <= ST_LIST_START;
                        end
                    end else if (|k_req) begin
                        owner     <= OWN_KIOSK;
                        kiosk_sel <= gnt_idx;
                        if ((occupancy == 4'(CAPACITY)) || (sel_id == 5'd0)) begin
                            k_nack <= gnt;
                            state  <= ST_ACK;
                        end else begin
                            mem_mode <= MODE_CHECKIN;
                            mem_id   <= sel_id;
                            mem_time <= sel_time;
                            state    <= ST_CMD;
                        end
                    end
                end

                ST_CMD: begin
                    mem_mode <= MODE_NOP;
                    state    <= ST_ACK;
                    if (owner == OWN_SRV) begin
                        srv_ack   <= 1'b1;
                        occupancy <= occupancy - 4'd1;
                    end else begin
                        k_ack     <= kiosk_sel ? 2'b10 : 2'b01;
                        occupancy <= occupancy + 4'd1;
                    end
                end

                // Response cycle: lets the requester drop its request before IDLE samples again.
                ST_ACK: begin
                    mem_mode <= MODE_NOP;
                    owner    <= OWN_NONE;
                    state    <= ST_IDLE;
                end

                ST_LIST_START: begin
                    mem_mode <= MODE_LIST;
                    lst_cnt  <= 4'd0;
                    run_cnt  <= 8'd0;
                    state    <= ST_LIST_RUN;
                end

                ST_LIST_RUN: begin
                    mem_mode <= MODE_LIST;
                    if (run_cnt == 8'(LIST_TIMEOUT - 1)) begin
                        mem_mode <= MODE_NOP;
                        lst_done <= 1'b1;
                        state    <= ST_LIST_END;
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                        if (lst_cnt < occupancy) begin
                            lst_id    <= mem_list;
                            lst_valid <= 1'b1;
                            lst_cnt   <= lst_cnt + 4'd1;
                        end else if (mem_ready && !mem_busy) begin
                            mem_mode <= MODE_NOP;
                            lst_done <= 1'b1;
                            state    <= ST_LIST_END;
                        end
                    end
                end

                ST_LIST_END: begin
                    mem_mode <= MODE_NOP;
                    owner    <= OWN_NONE;
                    state    <= ST_IDLE;
                end

                default: begin
                    mem_mode <= MODE_NOP;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pharmacy_sched.sv
// Directed testbench for pharmacy_sched with a behavioural queue memory that
// keeps entries ordered by check-in time and streams them out when listing.
module tb_pharmacy_sched;
    import pharmacy_pkg::*;

    localparam int CAP = 10;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  k_req = 2'b00;
    logic [9:0]  k_id = 10'd0;
    logic [15:0] k_time = 16'd0;
    logic [1:0]  k_ack, k_nack;
    logic        srv_req = 1'b0;
    logic        srv_ack, srv_nack;
    logic        lst_req = 1'b0;
    logic        lst_valid, lst_done;
    logic [4:0]  lst_id;
    logic [1:0]  mem_mode;
    logic [4:0]  mem_id;
    logic [7:0]  mem_time;
    logic [4:0]  mem_list = 5'd0;
    logic        mem_busy = 1'b0;
    logic        mem_ready = 1'b1;
    logic [3:0]  occupancy;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [4:0] exp_q[$];
    logic [4:0] got_q[$];

    // Queue memory model contents, kept sorted by time (earliest first).
    logic [4:0] mq_id[$];
    logic [7:0] mq_t[$];
    int         list_phase = 0;

    pharmacy_sched #(.CAPACITY(CAP), .LIST_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .k_req     (k_req),
        .k_id      (k_id),
        .k_time    (k_time),
        .k_ack     (k_ack),
        .k_nack    (k_nack),
        .srv_req   (srv_req),
        .srv_ack   (srv_ack),
        .srv_nack  (srv_nack),
        .lst_req   (lst_req),
        .lst_valid (lst_valid),
        .lst_id    (lst_id),
        .lst_done  (lst_done),
        .mem_mode  (mem_mode),
        .mem_id    (mem_id),
        .mem_time  (mem_time),
        .mem_list  (mem_list),
        .mem_busy  (mem_busy),
        .mem_ready (mem_ready),
        .occupancy (occupancy)
    );

    // Clock
    always #5 clk = ~clk;

    // Queue memory: acts on the command seen mid-cycle; a list streams one
    // entry per cycle starting in the second cycle of mode 00.
    always @(negedge clk) begin : mem_model
        int pos;
        if (rst) begin
            mq_id.delete();
            mq_t.delete();
            list_phase = 0;
            mem_busy   = 1'b0;
            mem_list   = 5'd0;
        end else begin
            if (mem_mode == MODE_CHECKIN) begin
                pos = mq_t.size();
                for (int i = 0; i < mq_t.size(); i++) begin
                    if (mq_t[i] > mem_time) begin
                        pos = i;
                        break;
                    end
                end
                mq_t.insert(pos, mem_time);
                mq_id.insert(pos, mem_id);
            end else if (mem_mode == MODE_DELETE && mq_t.size() > 0) begin
                void'(mq_t.pop_front());
                void'(mq_id.pop_front());
            end
            if (mem_mode == MODE_LIST) begin
                list_phase++;
                if (list_phase >= 2 && (list_phase - 2) < mq_id.size()) begin
                    mem_list = mq_id[list_phase - 2];
                    mem_busy = 1'b1;
                end else begin
                    mem_list = 5'd0;
                    mem_busy = (list_phase < 2);
                end
            end else begin
                list_phase = 0;
                mem_busy   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Driver: one kiosk check-in, held until ack/nack or budget expiry.
    task automatic drive_kiosk(input int k, input logic [4:0] id, input logic [7:0] t,
                               output int ack_cyc, output int nack_cyc, output int chk_cnt,
                               output logic [4:0] seen_id, output logic [7:0] seen_t);
        ack_cyc = 0; nack_cyc = 0; chk_cnt = 0; seen_id = 5'd0; seen_t = 8'd0;
        if (k == 0) begin
            k_id[4:0] = id; k_time[7:0] = t;
        end else begin
            k_id[9:5] = id; k_time[15:8] = t;
        end
        k_req[k] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (mem_mode == MODE_CHECKIN) begin
                chk_cnt++;
                seen_id = mem_id;
                seen_t  = mem_time;
            end
            if (k_ack[k]) begin ack_cyc = c; break; end
            if (k_nack[k]) begin nack_cyc = c; break; end
        end
        k_req[k] = 1'b0;
        tick();
    endtask

    // Driver: one pharmacist serve request.
    task automatic drive_srv(output int ack_cyc, output int nack_cyc,
                             output int del_cnt, output int cmd_cnt);
        ack_cyc = 0; nack_cyc = 0; del_cnt = 0; cmd_cnt = 0;
        srv_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (mem_mode == MODE_DELETE) del_cnt++;
            if (mem_mode != MODE_NOP) cmd_cnt++;
            if (srv_ack) begin ack_cyc = c; break; end
            if (srv_nack) begin nack_cyc = c; break; end
        end
        srv_req = 1'b0;
        tick();
    endtask

    // Driver: one list request; strobed IDs land in got_q.
    task automatic drive_list(output int done_cyc, output int list_cyc);
        done_cyc = 0; list_cyc = 0;
        got_q.delete();
        lst_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (mem_mode == MODE_LIST) list_cyc++;
            if (lst_valid) got_q.push_back(lst_id);
            if (lst_done) begin done_cyc = c; break; end
        end
        lst_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        vec_cnt++;
        if (mem_mode !== MODE_NOP) begin
            err_cnt++; $display("FAIL reset_mode: got %b want %b", mem_mode, MODE_NOP);
        end
        vec_cnt++;
        if ({mem_id, mem_time, lst_id} !== 18'd0) begin
            err_cnt++; $display("FAIL reset_data: got id %0d time %0d lst %0d want 0", mem_id, mem_time, lst_id);
        end
        vec_cnt++;
        if ({k_ack, k_nack, srv_ack, srv_nack, lst_valid, lst_done} !== 8'd0) begin
            err_cnt++; $display("FAIL reset_strobes: got %b want 0", {k_ack, k_nack, srv_ack, srv_nack, lst_valid, lst_done});
        end
        vec_cnt++;
        if (occupancy !== 4'd0) begin
            err_cnt++; $display("FAIL reset_occ: got %0d want 0", occupancy);
        end
    endtask

    task automatic test_serve_empty();
        int a, n, d, cm;
        drive_srv(a, n, d, cm);
        vec_cnt++;
        if (n !== 1 || a !== 0) begin
            err_cnt++; $display("FAIL serve_empty_nack: got nack@%0d ack@%0d want nack@1 ack@0", n, a);
        end
        vec_cnt++;
        if (cm !== 0) begin
            err_cnt++; $display("FAIL serve_empty_mode: got %0d command cycles want 0", cm);
        end
    endtask

    task automatic test_checkin();
        int a, n, ch, d, cm;
        logic [4:0] sid;
        logic [7:0] st;
        drive_kiosk(0, 5'd5, 8'd30, a, n, ch, sid, st);
        vec_cnt++;
        if (a !== 2 || n !== 0) begin
            err_cnt++; $display("FAIL checkin_ack: got ack@%0d nack@%0d want ack@2 nack@0", a, n);
        end
        vec_cnt++;
        if (ch !== 1 || sid !== 5'd5 || st !== 8'd30) begin
            err_cnt++; $display("FAIL checkin_cmd: got %0d cycles id %0d time %0d want 1 id 5 time 30", ch, sid, st);
        end
        vec_cnt++;
        if (occupancy !== 4'd1) begin
            err_cnt++; $display("FAIL checkin_occ: got %0d want 1", occupancy);
        end
        drive_srv(a, n, d, cm);
        vec_cnt++;
        if (a !== 2 || d !== 1 || occupancy !== 4'd0) begin
            err_cnt++; $display("FAIL serve_one: got ack@%0d del %0d occ %0d want ack@2 del 1 occ 0", a, d, occupancy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ev[$];
        logic [1:0] exp_ev[5];
        bit srv_raised;
        exp_ev = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
        do_reset();
        k_id = {5'd2, 5'd1};
        k_time = {8'd41, 8'd40};
        k_req = 2'b11;
        for (int c = 0; c < 40 && ev.size() < 2; c++) begin
            tick();
            if (k_ack[0]) begin ev.push_back(2'd0); k_req[0] = 1'b0; end
            if (k_ack[1]) begin ev.push_back(2'd1); k_req[1] = 1'b0; end
        end
        tick();
        k_id = {5'd4, 5'd3};
        k_time = {8'd43, 8'd42};
        k_req = 2'b11;
        srv_raised = 1'b0;
        for (int c = 0; c < 60 && ev.size() < 5; c++) begin
            tick();
            if (k_ack[0]) begin ev.push_back(2'd0); k_req[0] = 1'b0; end
            if (k_ack[1]) begin ev.push_back(2'd1); k_req[1] = 1'b0; end
            if (srv_ack) begin ev.push_back(2'd2); srv_req = 1'b0; end
            if (ev.size() == 3 && !srv_raised) begin
                srv_req = 1'b1;
                srv_raised = 1'b1;
            end
        end
        k_req = 2'b00;
        srv_req = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if (ev[i] !== exp_ev[i]) begin
                err_cnt++; $display("FAIL rr_order[%0d]: got %0d want %0d (0=k0 1=k1 2=srv)", i, ev[i], exp_ev[i]);
            end
        end
        vec_cnt++;
        if (occupancy !== 4'd3) begin
            err_cnt++; $display("FAIL rr_occ: got %0d want 3", occupancy);
        end
    endtask

    task automatic test_serve_three();
        int a, n, d, cm;
        drive_srv(a, n, d, cm);
        vec_cnt++;
        if (a !== 2 || d !== 1 || cm !== 1) begin
            err_cnt++; $display("FAIL serve3_cmd: got ack@%0d del %0d cmd %0d want 2 1 1", a, d, cm);
        end
        vec_cnt++;
        if (occupancy !== 4'd2) begin
            err_cnt++; $display("FAIL serve3_occ: got %0d want 2", occupancy);
        end
    endtask

    task automatic test_nack();
        int a, n, ch, d, cm, acked;
        logic [4:0] sid;
        logic [7:0] st;
        drive_kiosk(1, 5'd0, 8'd99, a, n, ch, sid, st);
        vec_cnt++;
        if (n !== 1 || a !== 0 || ch !== 0 || occupancy !== 4'd2) begin
            err_cnt++; $display("FAIL id0_nack: got nack@%0d ack@%0d cmd %0d occ %0d want 1 0 0 2", n, a, ch, occupancy);
        end
        acked = 0;
        for (int j = 0; j < 8; j++) begin
            drive_kiosk(0, 5'(10 + j), 8'(60 + j), a, n, ch, sid, st);
            if (a == 2) acked++;
        end
        vec_cnt++;
        if (acked !== 8 || occupancy !== 4'd10) begin
            err_cnt++; $display("FAIL fill: got %0d acks occ %0d want 8 acks occ 10", acked, occupancy);
        end
        drive_kiosk(1, 5'd20, 8'd90, a, n, ch, sid, st);
        vec_cnt++;
        if (n !== 1 || a !== 0 || ch !== 0) begin
            err_cnt++; $display("FAIL full_nack: got nack@%0d ack@%0d cmd %0d want 1 0 0", n, a, ch);
        end
        vec_cnt++;
        if (occupancy !== 4'd10) begin
            err_cnt++; $display("FAIL full_occ: got %0d want 10", occupancy);
        end
        acked = 0;
        for (int j = 0; j < 10; j++) begin
            drive_srv(a, n, d, cm);
            if (a == 2) acked++;
        end
        vec_cnt++;
        if (acked !== 10 || occupancy !== 4'd0) begin
            err_cnt++; $display("FAIL drain: got %0d acks occ %0d want 10 acks occ 0", acked, occupancy);
        end
    endtask

    task automatic test_list_empty();
        int dc, lc;
        drive_list(dc, lc);
        vec_cnt++;
        if (dc !== 1 || lc !== 0 || got_q.size() !== 0) begin
            err_cnt++; $display("FAIL list_empty: got done@%0d mode00 %0d strobes %0d want 1 0 0", dc, lc, got_q.size());
        end
    endtask

    task automatic test_list();
        int a, n, ch, dc, lc;
        logic [4:0] sid;
        logic [7:0] st;
        drive_kiosk(0, 5'd7, 8'd20, a, n, ch, sid, st);
        drive_kiosk(1, 5'd3, 8'd10, a, n, ch, sid, st);
        drive_kiosk(0, 5'd9, 8'd15, a, n, ch, sid, st);
        exp_q = '{5'd3, 5'd9, 5'd7};
        drive_list(dc, lc);
        vec_cnt++;
        if (got_q.size() !== 3) begin
            err_cnt++; $display("FAIL list_count: got %0d strobes want 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (got_q[i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL list_id[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        vec_cnt++;
        if (dc !== 6 || lc !== 5) begin
            err_cnt++; $display("FAIL list_timing: got done@%0d mode00 %0d want done@6 mode00 5", dc, lc);
        end
        vec_cnt++;
        if (mem_mode !== MODE_NOP) begin
            err_cnt++; $display("FAIL list_mode_after: got %b want %b", mem_mode, MODE_NOP);
        end
    endtask

    task automatic test_list_timeout();
        int dc, lc;
        mem_ready = 1'b0;
        drive_list(dc, lc);
        mem_ready = 1'b1;
        vec_cnt++;
        if (got_q.size() !== 3) begin
            err_cnt++; $display("FAIL tmo_count: got %0d strobes want 3", got_q.size());
        end
        vec_cnt++;
        if (dc !== TMO + 2 || lc !== TMO + 1) begin
            err_cnt++; $display("FAIL tmo_exit: got done@%0d mode00 %0d want done@%0d mode00 %0d", dc, lc, TMO + 2, TMO + 1);
        end
    endtask

    task automatic test_reset_mid_list();
        int seen, dones;
        seen = 0;
        lst_req = 1'b1;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            tick();
            if (lst_valid) seen = 1;
        end
        vec_cnt++;
        if (seen !== 1) begin
            err_cnt++; $display("FAIL midlist_reach: got no strobe within budget want strobe");
        end
        rst = 1'b1;
        lst_req = 1'b0;
        tick();
        vec_cnt++;
        if (mem_mode !== MODE_NOP) begin
            err_cnt++; $display("FAIL midlist_mode: got %b want %b", mem_mode, MODE_NOP);
        end
        vec_cnt++;
        if ({k_ack, k_nack, srv_ack, srv_nack, lst_valid, lst_done} !== 8'd0) begin
            err_cnt++; $display("FAIL midlist_strobes: got %b want 0", {k_ack, k_nack, srv_ack, srv_nack, lst_valid, lst_done});
        end
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (lst_done) dones++;
        end
        vec_cnt++;
        if (dones !== 0 || occupancy !== 4'd0) begin
            err_cnt++; $display("FAIL midlist_after: got %0d done pulses occ %0d want 0 0", dones, occupancy);
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_serve_empty();
        test_checkin();
        test_round_robin();
        test_serve_three();
        test_nack();
        test_list_empty();
        test_list();
        test_list_timeout();
        test_reset_mid_list();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Absolute time limit in case a bounded loop is ever bypassed.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
